// File: rtl/flash_raid_mirror_n.sv
// N-way RAID-1 SPI flash mirror: oversamples the host SPI port, re-drives it to every
// active flash channel, votes read data per bit and retires channels that keep dissenting.
module flash_raid_mirror_n #(
  parameter int NUM_FLASH   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 4,
  parameter int FAIL_THRESH = 3,
  localparam int PRIM_W     = (NUM_FLASH > 2) ? $clog2(NUM_FLASH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_sck,
  input  logic                       host_cs_n,
  input  logic                       host_mosi,
  output logic                       host_miso,
  output logic [NUM_FLASH-1:0]       flash_sck,
  output logic [NUM_FLASH-1:0]       flash_cs_n,
  output logic [NUM_FLASH-1:0]       flash_mosi,
  input  logic [NUM_FLASH-1:0]       flash_miso,
  input  logic [NUM_FLASH-1:0]       cfg_chan_en,
  input  logic [PRIM_W-1:0]          cfg_primary,
  input  logic                       cfg_clear_err,
  output logic [NUM_FLASH-1:0]       stat_active,
  output logic [NUM_FLASH-1:0]       stat_failed,
  output logic [PRIM_W-1:0]          stat_primary,
  output logic                       stat_tie_err,
  output logic [NUM_FLASH*ERR_W-1:0] stat_err_cnt,
  output logic                       stat_busy,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(NUM_FLASH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CLOSE  = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sy, cs_sy, mosi_sy;
  logic sck_s, cs_s, mosi_s;
  logic sck_q, cs_q;
  logic sck_rise, cs_fall, cs_rise;

  logic [15:0]          bit_cnt;
  logic [7:0]           opcode;
  logic                 cmp_pend;
  logic                 clr_pend;
  logic [NUM_FLASH-1:0] mism;

  logic [NUM_FLASH-1:0] act_new;
  logic                 in_window;
  logic [CW-1:0]        n_act, n_one, n_zero;
  logic                 maj_one, maj_zero, multi_act;
  logic [NUM_FLASH-1:0] dissent;
  logic                 clr_now;
  logic [NUM_FLASH*ERR_W-1:0] err_nx;
  logic [NUM_FLASH-1:0] fail_nx;
  logic [NUM_FLASH-1:0] fail_use;
  logic [PRIM_W-1:0]    prim_nx;

  assign dbg_state = state;

  // Synchroniser chains reset to the idle bus levels so no edge is seen out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sy  <= '0;
      cs_sy   <= '1;
      mosi_sy <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      sck_sy[0]  <= host_sck;
      cs_sy[0]   <= host_cs_n;
      mosi_sy[0] <= host_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sy[i]  <= sck_sy[i-1];
        cs_sy[i]   <= cs_sy[i-1];
        mosi_sy[i] <= mosi_sy[i-1];
      end
      sck_q <= sck_s;
      cs_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sy[SYNC_STAGES-1];
  assign cs_s     = cs_sy[SYNC_STAGES-1];
  assign mosi_s   = mosi_sy[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;

  assign act_new   = cfg_chan_en & ~stat_failed;
  assign in_window = ((opcode == 8'h03) && (bit_cnt >= 16'd32)) ||
                     ((opcode == 8'h0B) && (bit_cnt >= 16'd40));

  always_comb begin
    host_miso = 1'b0;
    for (int i = 0; i < NUM_FLASH; i++) begin
      if (PRIM_W'(i) == stat_primary) host_miso = flash_miso[i];
    end
  end

  // Majority vote over the active channels; a dissenter is any active channel not matching it.
  always_comb begin
    n_act = '0;
    n_one = '0;
    for (int i = 0; i < NUM_FLASH; i++) begin
      n_act = n_act + {{(CW-1){1'b0}}, stat_active[i]};
      n_one = n_one + {{(CW-1){1'b0}}, stat_active[i] & flash_miso[i]};
    end
    n_zero    = n_act - n_one;
    maj_one   = {n_one, 1'b0} > {1'b0, n_act};
    maj_zero  = {n_zero, 1'b0} > {1'b0, n_act};
    multi_act = n_act > CW'(1);
    dissent   = stat_active & (flash_miso ^ {NUM_FLASH{maj_one}});
  end

  assign clr_now = clr_pend | cfg_clear_err;

  always_comb begin
    logic [ERR_W-1:0] c;
    c       = '0;
    err_nx  = stat_err_cnt;
    fail_nx = stat_failed;
    for (int i = 0; i < NUM_FLASH; i++) begin
      c = stat_err_cnt[i*ERR_W +: ERR_W];
      if (mism[i] && (c != {ERR_W{1'b1}})) c = c + 1'b1;
      err_nx[i*ERR_W +: ERR_W] = c;
      if (c >= ERR_W'(FAIL_THRESH)) fail_nx[i] = 1'b1;
    end
    if (clr_now) begin
      err_nx  = '0;
      fail_nx = '0;
    end
  end

  // Requested primary if usable, else lowest usable channel, else keep the current one.
  always_comb begin
    fail_use = (state == ST_CLOSE) ? fail_nx : stat_failed;
    prim_nx  = stat_primary;
    for (int i = NUM_FLASH - 1; i >= 0; i--) begin
      if (cfg_chan_en[i] && !fail_use[i]) prim_nx = PRIM_W'(i);
    end
    for (int i = 0; i < NUM_FLASH; i++) begin
      if ((PRIM_W'(i) == cfg_primary) && cfg_chan_en[i] && !fail_use[i]) prim_nx = cfg_primary;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      flash_cs_n   <= '1;
      flash_sck    <= '0;
      flash_mosi   <= '0;
      stat_active  <= '0;
      stat_failed  <= '0;
      stat_err_cnt <= '0;
      stat_tie_err <= 1'b0;
      stat_busy    <= 1'b0;
      stat_primary <= '0;
      bit_cnt      <= '0;
      opcode       <= '0;
      cmp_pend     <= 1'b0;
      clr_pend     <= 1'b0;
      mism         <= '0;
    end else begin
      cmp_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          flash_cs_n   <= '1;
          flash_sck    <= '0;
          flash_mosi   <= '0;
          stat_primary <= prim_nx;
          if (cfg_clear_err) begin
            stat_err_cnt <= '0;
            stat_failed  <= '0;
            stat_tie_err <= 1'b0;
          end
          if (cs_fall) begin
            stat_active <= act_new;
            if (act_new != '0) begin
              flash_cs_n <= ~act_new;
              flash_sck  <= act_new & {NUM_FLASH{sck_s}};
              flash_mosi <= act_new & {NUM_FLASH{mosi_s}};
              stat_busy  <= 1'b1;
              state      <= ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          flash_cs_n <= ~stat_active;
          flash_sck  <= stat_active & {NUM_FLASH{sck_s}};
          flash_mosi <= stat_active & {NUM_FLASH{mosi_s}};
          if (cfg_clear_err) clr_pend <= 1'b1;
          if (sck_rise) begin
            if (bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
            if (bit_cnt < 16'd8) opcode <= {opcode[6:0], mosi_s};
            cmp_pend <= in_window;
          end
          // cmp_pend lands in the cycle the flash pins see their sck rise.
          if (cmp_pend && multi_act) begin
            if (maj_one || maj_zero) mism <= mism | dissent;
            else                     stat_tie_err <= 1'b1;
          end
          if (cs_rise) begin
            flash_cs_n <= '1;
            flash_sck  <= '0;
            flash_mosi <= '0;
            state      <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          flash_cs_n   <= '1;
          flash_sck    <= '0;
          flash_mosi   <= '0;
          stat_err_cnt <= err_nx;
          stat_failed  <= fail_nx;
          if (clr_now) stat_tie_err <= 1'b0;
          stat_primary <= prim_nx;
          mism         <= '0;
          bit_cnt      <= '0;
          opcode       <= '0;
          clr_pend     <= 1'b0;
          stat_busy    <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_raid_mirror_n.sv
// Directed bench for flash_raid_mirror_n with three channels: a transaction vector table
// plus hand sequences for lag, partial frames, deferred clear and asynchronous reset.
module tb_flash_raid_mirror_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_sck, host_cs_n, host_mosi;
  wire         host_miso;
  logic [2:0]  flash_sck, flash_cs_n, flash_mosi;
  wire  [2:0]  flash_miso;
  logic [2:0]  cfg_chan_en;
  logic [1:0]  cfg_primary;
  logic        cfg_clear_err;
  logic [2:0]  stat_active, stat_failed;
  logic [1:0]  stat_primary;
  logic        stat_tie_err;
  logic [11:0] stat_err_cnt;
  logic        stat_busy;
  logic [1:0]  dbg_state;

  flash_raid_mirror_n #(.NUM_FLASH(3), .SYNC_STAGES(2), .ERR_W(4), .FAIL_THRESH(3)) dut (
    .clk(clk), .rst(rst),
    .host_sck(host_sck), .host_cs_n(host_cs_n), .host_mosi(host_mosi), .host_miso(host_miso),
    .flash_sck(flash_sck), .flash_cs_n(flash_cs_n), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
    .cfg_chan_en(cfg_chan_en), .cfg_primary(cfg_primary), .cfg_clear_err(cfg_clear_err),
    .stat_active(stat_active), .stat_failed(stat_failed), .stat_primary(stat_primary),
    .stat_tie_err(stat_tie_err), .stat_err_cnt(stat_err_cnt), .stat_busy(stat_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- flash models ----------------
  // Mode 0 flash: shifts a 24-bit response MSB first from the falling edge after bit 31.
  logic [23:0] resp [3];

  for (genvar g = 0; g < 3; g++) begin : g_flash
    logic m   = 1'b0;
    int   cnt = 0;
    always @(negedge flash_sck[g] or posedge flash_cs_n[g]) begin
      if (flash_cs_n[g]) begin
        cnt <= 0;
        m   <= 1'b0;
      end else begin
        cnt <= cnt + 1;
        if ((cnt + 1 >= 32) && (cnt + 1 < 56)) m <= resp[g][55 - (cnt + 1)];
        else                                   m <= 1'b0;
      end
    end
    assign flash_miso[g] = m;
  end

  // ---------------- monitors ----------------
  logic [3:0] mosi_h = '0, sck_h = '0;
  logic       mon_en = 1'b0;
  int         lag_err = 0;
  int         close_cnt = 0;

  always @(negedge clk) begin
    mosi_h <= {mosi_h[2:0], host_mosi};
    sck_h  <= {sck_h[2:0], host_sck};
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (!flash_cs_n[i]) begin
          if ((flash_mosi[i] !== mosi_h[2]) || (flash_sck[i] !== sck_h[2])) lag_err <= lag_err + 1;
        end else if (flash_sck[i] !== 1'b0) begin
          lag_err <= lag_err + 1;
        end
      end
    end
    if (dbg_state == 2'd2) close_cnt <= close_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  logic       busy_mid;
  logic [2:0] cs_mid;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    host_mosi = b;
    wait_clk(8);
    r = host_miso;
    host_sck = 1'b1;
    wait_clk(8);
    host_sck = 1'b0;
  endtask

  task automatic spi_xfer(input logic [63:0] frame, input int nbits, input int clr_at,
                          output logic [15:0] rx);
    logic r;
    rx = '0;
    host_cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == clr_at) begin
        cfg_clear_err = 1'b1;
        wait_clk(1);
        cfg_clear_err = 1'b0;
      end
      if (i == 4) begin
        busy_mid = stat_busy;
        cs_mid   = flash_cs_n;
      end
      spi_bit(frame[63-i], r);
      rx = {rx[14:0], r};
    end
    wait_clk(8);
    host_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic pulse_clear();
    cfg_clear_err = 1'b1;
    wait_clk(1);
    cfg_clear_err = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        clr_before;
    logic [2:0]  chan_en;
    logic [1:0]  prim;
    logic [63:0] frame;
    int          nbits;
    logic [23:0] r0, r1, r2;
    logic [15:0] exp_rx;
    logic [11:0] exp_err;
    logic [2:0]  exp_failed;
    logic        exp_tie;
    logic [2:0]  exp_active;
    logic [1:0]  exp_prim;
  } vec_t;

  localparam logic [63:0] F03 = {8'h03, 24'h000100, 32'h0};
  localparam logic [63:0] F0B = {8'h0B, 24'h000100, 32'h0};
  localparam logic [63:0] F05 = {8'h05, 56'h0};
  localparam logic [63:0] F06 = {8'h06, 56'h0};

  vec_t vecs[11];

  initial begin
    logic [15:0] rx;
    int          cc0;

    vecs[0]  = '{1'b0, 3'b111, 2'd0, F03, 48, 24'hA5A500, 24'hA5A500, 24'h5A5A00, 16'hA5A5, 12'h100, 3'b000, 1'b0, 3'b111, 2'd0};
    vecs[1]  = '{1'b0, 3'b111, 2'd0, F03, 48, 24'hA5A500, 24'hA5A500, 24'h5A5A00, 16'hA5A5, 12'h200, 3'b000, 1'b0, 3'b111, 2'd0};
    vecs[2]  = '{1'b0, 3'b111, 2'd0, F03, 48, 24'hA5A500, 24'hA5A500, 24'h5A5A00, 16'hA5A5, 12'h300, 3'b100, 1'b0, 3'b111, 2'd0};
    vecs[3]  = '{1'b0, 3'b111, 2'd0, F03, 48, 24'hA5A500, 24'hA5A500, 24'h5A5A00, 16'hA5A5, 12'h300, 3'b100, 1'b0, 3'b011, 2'd0};
    vecs[4]  = '{1'b0, 3'b011, 2'd0, F03, 48, 24'hA5A500, 24'hA5A400, 24'h000000, 16'hA5A5, 12'h300, 3'b100, 1'b1, 3'b011, 2'd0};
    vecs[5]  = '{1'b1, 3'b111, 2'd0, F03, 48, 24'h5A5A00, 24'hA5A500, 24'hA5A500, 16'h5A5A, 12'h001, 3'b000, 1'b0, 3'b111, 2'd0};
    vecs[6]  = '{1'b0, 3'b111, 2'd0, F03, 48, 24'h5A5A00, 24'hA5A500, 24'hA5A500, 16'h5A5A, 12'h002, 3'b000, 1'b0, 3'b111, 2'd0};
    vecs[7]  = '{1'b0, 3'b111, 2'd0, F03, 48, 24'h5A5A00, 24'hA5A500, 24'hA5A500, 16'h5A5A, 12'h003, 3'b001, 1'b0, 3'b111, 2'd1};
    vecs[8]  = '{1'b0, 3'b111, 2'd0, F0B, 56, 24'hFFFFFF, 24'hFF3C3C, 24'h003C3C, 16'h3C3C, 12'h003, 3'b001, 1'b0, 3'b110, 2'd1};
    vecs[9]  = '{1'b0, 3'b111, 2'd0, F05, 48, 24'h000000, 24'h123456, 24'h654321, 16'h1234, 12'h003, 3'b001, 1'b0, 3'b110, 2'd1};
    vecs[10] = '{1'b0, 3'b111, 2'd0, F0B, 56, 24'h000000, 24'h003C3C, 24'h003C3D, 16'h3C3C, 12'h003, 3'b001, 1'b1, 3'b110, 2'd1};

    resp[0] = '0; resp[1] = '0; resp[2] = '0;
    rst = 1'b1;
    host_sck = 1'b0; host_cs_n = 1'b1; host_mosi = 1'b0;
    cfg_chan_en = 3'b011; cfg_primary = 2'd0; cfg_clear_err = 1'b0;
    wait_clk(4);

    chk("rst_flash_cs_n", flash_cs_n, 3'b111);
    chk("rst_flash_sck", flash_sck, 3'b000);
    chk("rst_flash_mosi", flash_mosi, 3'b000);
    chk("rst_active", stat_active, 3'b000);
    chk("rst_failed", stat_failed, 3'b000);
    chk("rst_err_cnt", stat_err_cnt, 12'h000);
    chk("rst_tie", stat_tie_err, 1'b0);
    chk("rst_busy", stat_busy, 1'b0);
    chk("rst_primary", stat_primary, 2'd0);
    rst = 1'b0;
    wait_clk(4);
    chk("idle_state", dbg_state, 2'd0);

    // Write-enable on two channels: pins lag the host by three clocks, ch2 stays quiet.
    mon_en = 1'b1;
    spi_xfer(F06, 8, -1, rx);
    mon_en = 1'b0;
    chk("wren_cs_mid", cs_mid, 3'b100);
    chk("wren_busy_mid", busy_mid, 1'b1);
    chk("wren_lag_errs", lag_err, 0);
    chk("wren_busy_end", stat_busy, 1'b0);
    chk("wren_cs_end", flash_cs_n, 3'b111);
    chk("wren_err_cnt", stat_err_cnt, 12'h000);
    chk("wren_active", stat_active, 3'b011);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].clr_before) begin
        pulse_clear();
        chk($sformatf("v%0d_clr_err", v), stat_err_cnt, 12'h000);
        chk($sformatf("v%0d_clr_failed", v), stat_failed, 3'b000);
        chk($sformatf("v%0d_clr_tie", v), stat_tie_err, 1'b0);
      end
      cfg_chan_en = vecs[v].chan_en;
      cfg_primary = vecs[v].prim;
      resp[0] = vecs[v].r0;
      resp[1] = vecs[v].r1;
      resp[2] = vecs[v].r2;
      wait_clk(2);
      spi_xfer(vecs[v].frame, vecs[v].nbits, -1, rx);
      chk($sformatf("v%0d_rx", v), rx, vecs[v].exp_rx);
      chk($sformatf("v%0d_err_cnt", v), stat_err_cnt, vecs[v].exp_err);
      chk($sformatf("v%0d_failed", v), stat_failed, vecs[v].exp_failed);
      chk($sformatf("v%0d_tie", v), stat_tie_err, vecs[v].exp_tie);
      chk($sformatf("v%0d_active", v), stat_active, vecs[v].exp_active);
      chk($sformatf("v%0d_primary", v), stat_primary, vecs[v].exp_prim);
      chk($sformatf("v%0d_busy", v), stat_busy, 1'b0);
      chk($sformatf("v%0d_cs_end", v), flash_cs_n, 3'b111);
    end

    // Fast read abandoned after 20 bits: no compare, a single CLOSE cycle.
    cc0 = close_cnt;
    spi_xfer(F0B, 20, -1, rx);
    chk("abort_close_cycles", close_cnt - cc0, 1);
    chk("abort_cs", flash_cs_n, 3'b111);
    chk("abort_busy", stat_busy, 1'b0);
    chk("abort_state", dbg_state, 2'd0);
    chk("abort_err_cnt", stat_err_cnt, 12'h003);
    chk("abort_tie", stat_tie_err, 1'b1);

    // Clear while idle; the primary falls back to the requested ch0 once it is healthy.
    pulse_clear();
    chk("idle_clr_err", stat_err_cnt, 12'h000);
    chk("idle_clr_failed", stat_failed, 3'b000);
    chk("idle_clr_tie", stat_tie_err, 1'b0);
    wait_clk(1);
    chk("idle_clr_primary", stat_primary, 2'd0);

    // Read ending mid-byte: the four data bits already voted still count.
    resp[0] = 24'hA5A500; resp[1] = 24'hA5A500; resp[2] = 24'h5A5A00;
    spi_xfer(F03, 36, -1, rx);
    chk("partial_err_cnt", stat_err_cnt, 12'h100);
    chk("partial_failed", stat_failed, 3'b000);

    // Clear during ACTIVE with a pending mismatch wins over the CLOSE increment.
    spi_xfer(F03, 36, 34, rx);
    chk("defer_clr_err", stat_err_cnt, 12'h000);
    chk("defer_clr_failed", stat_failed, 3'b000);
    chk("defer_clr_tie", stat_tie_err, 1'b0);

    // Reset in the middle of a byte releases CS asynchronously.
    host_cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, rx[0]);
    host_mosi = 1'b1;
    host_sck  = 1'b1;
    wait_clk(4);
    chk("pre_rst_cs", flash_cs_n, 3'b000);
    chk("pre_rst_busy", stat_busy, 1'b1);
    rst = 1'b1;
    #2;
    chk("mid_rst_cs", flash_cs_n, 3'b111);
    chk("mid_rst_sck", flash_sck, 3'b000);
    chk("mid_rst_busy", stat_busy, 1'b0);
    chk("mid_rst_active", stat_active, 3'b000);
    chk("mid_rst_state", dbg_state, 2'd0);
    host_sck  = 1'b0;
    host_cs_n = 1'b1;
    host_mosi = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    chk("post_rst_cs", flash_cs_n, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_raid_mirror_n.md
Name: flash_raid_mirror_n

Overview:
- N-way RAID-1 SPI flash mirror engine; successor to the fixed two-flash raider path.
- One host SPI port (mode 0) is oversampled in the clk domain and re-driven, bit for bit, to NUM_FLASH flash channels.
- Host MISO comes from the current primary channel.
- On read commands, every active channel's MISO is sampled and majority-voted per bit. Dissenting channels accumulate errors and are retired automatically; the primary fails over to a healthy channel.

Parameters:
- NUM_FLASH, 2, number of mirrored flash channels (2..8).
- SYNC_STAGES, 2, synchroniser depth on host_sck/host_cs_n/host_mosi.
- ERR_W, 4, width of each per-channel saturating error counter.
- FAIL_THRESH, 3, error count at which a channel is marked failed (1..2^ERR_W-1).

Ports:
- clk  in  1  system clock; host SCK must be <= clk/8.
- rst  in  1  asynchronous active-high reset.
- host_sck  in  1  host SPI clock.
- host_cs_n  in  1  host chip select, active low.
- host_mosi  in  1  host data in.
- host_miso  out  1  host data out.
- flash_sck  out  NUM_FLASH  per-channel flash clock.
- flash_cs_n  out  NUM_FLASH  per-channel flash chip select.
- flash_mosi  out  NUM_FLASH  per-channel flash data out.
- flash_miso  in  NUM_FLASH  per-channel flash data in.
- cfg_chan_en  in  NUM_FLASH  channel enable mask.
- cfg_primary  in  PRIM_W  requested primary index; PRIM_W = max(1, clog2(NUM_FLASH)).
- cfg_clear_err  in  1  one-cycle pulse: clears counters, failed flags, tie flag.
- stat_active  out  NUM_FLASH  mask of channels in the current or last transaction.
- stat_failed  out  NUM_FLASH  retired channels.
- stat_primary  out  PRIM_W  effective primary index.
- stat_tie_err  out  1  sticky flag: a vote with no strict majority occurred.
- stat_err_cnt  out  NUM_FLASH*ERR_W  packed counters; channel i at [i*ERR_W +: ERR_W].
- stat_busy  out  1  transaction in progress.

Behaviour:
- Reset values:
  - flash_cs_n all 1; flash_sck and flash_mosi all 0.
  - stat_active, stat_failed, stat_err_cnt, stat_tie_err, stat_busy all 0; stat_primary 0.
  - Synchroniser flops reset to the idle values (sck=0, cs_n=1, mosi=0).
- Host inputs pass through SYNC_STAGES flops, then one output register. Flash pins lag host pins by SYNC_STAGES+1 clk.
- host_miso = flash_miso[stat_primary], purely combinational. No vote on this path.
- State machine IDLE -> ACTIVE -> CLOSE -> IDLE.
  - IDLE: on synced cs_n falling, latch active = cfg_chan_en & ~stat_failed, and latch the primary. If active is empty, stay in IDLE and drive no flash CS. Otherwise assert flash_cs_n low on active channels only, same cycle as the registered cs, and go to ACTIVE with stat_busy=1.
  - ACTIVE: mirror sck/mosi to active channels; inactive channels hold sck=0, cs_n=1. On each synced sck rising edge, bit_cnt increments (16-bit, saturating). Bits 0..7 shift into the opcode register.
  - Compare window: opcode 0x03 at bit_cnt >= 32; opcode 0x0B at bit_cnt >= 40; no other opcode. Inside the window, on each flash-side sck rise, sample flash_miso of active channels and take a majority:
    - Strict majority (> half of active channels): each dissenter sets its mismatch flag for this transaction.
    - Otherwise: set stat_tie_err and blame no channel.
    - Only one active channel: no compare.
  - synced cs_n rising (any bit position, including mid-byte) -> CLOSE. Partial-byte compares already taken count.
  - CLOSE, one cycle: deassert all flash_cs_n. Each flagged channel increments its error counter once, saturating at 2^ERR_W-1. A counter reaching >= FAIL_THRESH sets stat_failed[i]. Clear flags and bit_cnt; stat_busy=0; -> IDLE.
- Primary selection, evaluated in CLOSE and on cfg writes while IDLE:
  - Use cfg_primary if it is enabled and not failed.
  - Else use the lowest-index channel that is enabled and not failed.
  - If none exists, hold the previous value.
  - The primary never changes during ACTIVE.
- cfg_clear_err:
  - In IDLE: takes effect next cycle.
  - In ACTIVE: deferred until after CLOSE updates, so it wins over the increment.
- cfg_chan_en and cfg_primary changes during ACTIVE are ignored until the next transaction.
- rst mid-transaction: all outputs return to reset values immediately; the flash sees CS rise asynchronously.

Test Plan:
- NUM_FLASH=2, both enabled. Host sends 0x06 (8 bits) -> both flash_cs_n low, flash_mosi streams match host_mosi delayed 3 clk; counters stay 0; stat_busy 1→0.
- NUM_FLASH=3. Read 0x03 addr 0x000100, 2 data bytes; channel 2 returns 0x5A vs 0xA5 from the others -> host_miso carries ch0 data; stat_err_cnt[2]=1; others 0.
- Repeat the previous case 3 times -> stat_failed=3'b100. The next transaction asserts cs only on ch0/ch1; stat_active=3'b011.
- NUM_FLASH=2, cfg_primary=0. Channels disagree on a data bit -> stat_tie_err=1, no counter increments. Then fail ch0 via 3 majority losses in a 3-channel configuration -> stat_primary fails over to 1.
- Host cs_n rises after 20 bits of opcode 0x0B -> no compare; CLOSE in one cycle; all flash_cs_n=1. Assert rst mid-byte -> flash_cs_n all 1 the same cycle.
- cfg_clear_err pulsed during ACTIVE with a pending mismatch -> after CLOSE, all counters and stat_failed are 0.
